// File: rtl/uart_rx_pkg.sv
`default_nettype none
//--------------------------------------------------------------------
// uart_rx_pkg : frame FSM state codes and line constants, UART receiver
// Rev 1.0
//--------------------------------------------------------------------
package uart_rx_pkg;

  typedef logic [2:0] state_t;

  // Adjacent states differ in one bit along the normal frame path.
  localparam state_t c_IDLE       = 3'b000;
  localparam state_t c_START      = 3'b001;
  localparam state_t c_DATA       = 3'b011;
  localparam state_t c_PARITY     = 3'b010;
  localparam state_t c_STOP       = 3'b110;
  localparam state_t c_DONE       = 3'b111;
  localparam state_t c_BREAK_WAIT = 3'b101;

  localparam logic c_PAR_EVEN = 1'b0;
  localparam logic c_PAR_ODD  = 1'b1;

  localparam int c_PRESC_MIN = 6;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
//--------------------------------------------------------------------
// uart_rx_sampler : 3-sample majority vote around the bit centre
// Rev 1.0
//--------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_rx,
  input  logic [PRESC_W-1:0] i_edge_cnt,
  input  logic [PRESC_W-1:0] i_half,
  output logic               o_majority,
  output logic               o_sample_done
);

  localparam logic [PRESC_W-1:0] c_ONE = PRESC_W'(1);

  logic               r_s0;
  logic               r_s1;
  logic [PRESC_W-1:0] w_edge_first;
  logic [PRESC_W-1:0] w_edge_decide;

  assign w_edge_first  = i_half - c_ONE;
  assign w_edge_decide = i_half + c_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (i_edge_cnt == w_edge_first) r_s0 <= i_rx;
      if (i_edge_cnt == i_half)       r_s1 <= i_rx;
    end
  end

  // Third sample is the live line, so the vote is ready on the decision edge itself.
  assign o_sample_done = (i_edge_cnt == w_edge_decide);
  assign o_majority    = maj3(r_s0, r_s1, i_rx);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
//--------------------------------------------------------------------
// uart_rx_frame_ctrl : UART receive frame FSM, deserialiser, parity/stop check
// Rev 1.0
//--------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               Par_En,
  input  logic               Par_Typ,
  input  logic               Stp_Two,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               Data_Valid,
  output logic               Par_Err,
  output logic               Stp_Err,
  output logic               Busy
);

  localparam logic [PRESC_W-1:0] c_ONE       = PRESC_W'(1);
  localparam logic [3:0]         c_DATA_BITS = 4'(DATA_W);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PRESC_W-1:0] r_edge_cnt;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_half;
  logic [3:0]         r_bit_cnt;
  logic [3:0]         w_last_bit;
  logic               r_par_en;
  logic               r_par_typ;
  logic               r_stp_two;
  logic               r_par_bad;
  logic               r_stp_bad;
  logic [DATA_W-1:0]  r_shift;
  logic               w_majority;
  logic               w_sample_done;
  logic               w_bit_end;
  logic               w_start_edge;
  logic               w_in_frame_nxt;
  logic               w_frame_end;
  logic               w_stp_bad_fin;
  logic               w_par_exp;
  logic               w_frame_good;

  assign w_half        = r_presc >> 1;
  assign w_bit_end     = (r_edge_cnt == (r_presc - c_ONE));
  assign w_last_bit    = c_DATA_BITS + {3'b000, r_par_en} + {3'b000, r_stp_two} + 4'd1;
  assign w_start_edge  = (r_state == c_IDLE) && !RX_IN;
  assign w_par_exp     = (^r_shift) ^ (r_par_typ == c_PAR_ODD);
  assign w_stp_bad_fin = r_stp_bad | !w_majority;
  assign w_frame_good  = !r_par_bad && !w_stp_bad_fin;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rx          (RX_IN),
    .i_edge_cnt    (r_edge_cnt),
    .i_half        (w_half),
    .o_majority    (w_majority),
    .o_sample_done (w_sample_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (!RX_IN) w_state_nxt = c_START;
      end
      c_START: begin
        if (w_sample_done && w_majority) w_state_nxt = c_IDLE;
        else if (w_bit_end)              w_state_nxt = c_DATA;
      end
      c_DATA: begin
        if (w_bit_end && (r_bit_cnt == c_DATA_BITS))
          w_state_nxt = r_par_en ? c_PARITY : c_STOP;
      end
      c_PARITY: begin
        if (w_bit_end) w_state_nxt = c_STOP;
      end
      c_STOP: begin
        // Leave mid-bit on the last stop so the next start edge is caught early.
        if (w_sample_done && (r_bit_cnt == w_last_bit)) begin
          w_state_nxt = c_DONE;
          w_frame_end = 1'b1;
        end
      end
      c_DONE: begin
        w_state_nxt = (r_stp_bad && !RX_IN) ? c_BREAK_WAIT : c_IDLE;
      end
      c_BREAK_WAIT: begin
        if (RX_IN) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  assign w_in_frame_nxt = (w_state_nxt == c_START) || (w_state_nxt == c_DATA) ||
                          (w_state_nxt == c_PARITY) || (w_state_nxt == c_STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The start-edge cycle counts as edge 0, so the counter resumes at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_start_edge) begin
      r_edge_cnt <= c_ONE;
      r_bit_cnt  <= '0;
    end else if (!w_in_frame_nxt) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_bit_end) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 4'd1;
    end else begin
      r_edge_cnt <= r_edge_cnt + c_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= c_PAR_EVEN;
      r_stp_two <= 1'b0;
      r_par_bad <= 1'b0;
      r_stp_bad <= 1'b0;
      r_shift   <= '0;
    end else if (w_start_edge) begin
      r_presc   <= Prescale;
      r_par_en  <= Par_En;
      r_par_typ <= Par_Typ;
      r_stp_two <= Stp_Two;
      r_par_bad <= 1'b0;
      r_stp_bad <= 1'b0;
      r_shift   <= '0;
    end else if (w_sample_done) begin
      case (r_state)
        c_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (r_bit_cnt == 4'(i + 1)) r_shift[i] <= w_majority;
          end
        end
        c_PARITY: if (w_majority != w_par_exp) r_par_bad <= 1'b1;
        c_STOP:   if (!w_majority) r_stp_bad <= 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      Data_Valid <= w_frame_end && w_frame_good;
      Par_Err    <= w_frame_end && r_par_bad;
      Stp_Err    <= w_frame_end && w_stp_bad_fin;
      if (w_frame_end && w_frame_good) P_DATA <= r_shift;
    end
  end

  assign Busy = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//--------------------------------------------------------------------
// tb_uart_rx_frame_ctrl : self-checking bench for uart_rx_frame_ctrl
// Rev 1.0
//--------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx8, rx7;
  logic [5:0] Prescale;
  logic       Par_En, Par_Typ, Stp_Two;
  logic [7:0] pd8;
  logic [6:0] pd7;
  logic       dv8, pe8, se8, busy8;
  logic       dv7, pe7, se7, busy7;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.DATA_W(8), .PRESC_W(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .RX_IN(rx8), .Prescale(Prescale), .Par_En(Par_En),
    .Par_Typ(Par_Typ), .Stp_Two(Stp_Two), .P_DATA(pd8), .Data_Valid(dv8),
    .Par_Err(pe8), .Stp_Err(se8), .Busy(busy8));

  uart_rx_frame_ctrl #(.DATA_W(7), .PRESC_W(6)) dut7 (
    .clk(clk), .rst_n(rst_n), .RX_IN(rx7), .Prescale(Prescale), .Par_En(Par_En),
    .Par_Typ(Par_Typ), .Stp_Two(Stp_Two), .P_DATA(pd7), .Data_Valid(dv7),
    .Par_Err(pe7), .Stp_Err(se7), .Busy(busy7));

  typedef struct {
    int         cyc;
    bit         dv, pe, se;
    logic [8:0] pd;
  } ev_t;

  typedef struct {
    bit         sel7;
    logic [8:0] data;
    bit         pe, pt, two;
    int         p;
    bit         flip, s1b, s2b;
    bit         e_dv, e_pe, e_se;
    logic [8:0] e_pd;
  } vec_t;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  q8[$];
  ev_t  q7[$];
  bit   fbits[$];
  vec_t tbl[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    ev_t e;
    if (dv8 || pe8 || se8) begin
      e.cyc = cyc; e.dv = dv8; e.pe = pe8; e.se = se8; e.pd = {1'b0, pd8};
      q8.push_back(e);
    end
    if (dv7 || pe7 || se7) begin
      e.cyc = cyc; e.dv = dv7; e.pe = pe7; e.se = se7; e.pd = {2'b00, pd7};
      q7.push_back(e);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit sel7, input bit v);
    if (sel7) rx7 = v;
    else      rx8 = v;
  endtask

  task automatic apply_cfg(input int p, input bit pe, input bit pt, input bit two);
    Prescale = 6'(p);
    Par_En   = pe;
    Par_Typ  = pt;
    Stp_Two  = two;
  endtask

  // Frame as line bits: start, data LSB first, optional parity, stop bit(s).
  task automatic build_frame(input int dw, input logic [8:0] data, input bit pe, input bit pt,
                             input bit two, input bit flip, input bit s1b, input bit s2b);
    bit x;
    fbits.delete();
    fbits.push_back(1'b0);
    x = pt ^ flip;
    for (int i = 0; i < dw; i++) begin
      fbits.push_back(data[i]);
      x ^= data[i];
    end
    if (pe) fbits.push_back(x);
    fbits.push_back(!s1b);
    if (two) fbits.push_back(!s2b);
  endtask

  // Configuration inputs are scrambled after the start edge; the DUT must ignore that.
  task automatic send_frame(input bit sel7, input int p, input int last_len, output int start);
    start = cyc;
    for (int i = 0; i < fbits.size(); i++) begin
      set_rx(sel7, fbits[i]);
      if (i == 0) begin
        hold(1);
        Prescale = 6'($urandom_range(0, 63));
        Par_En   = 1'($urandom_range(0, 1));
        Par_Typ  = 1'($urandom_range(0, 1));
        Stp_Two  = 1'($urandom_range(0, 1));
        hold(p - 1);
      end else if (i == fbits.size() - 1) begin
        hold(last_len);
      end else begin
        hold(p);
      end
    end
    set_rx(sel7, 1'b1);
  endtask

  function automatic int lat(input int dw, input bit pe, input bit two, input int p);
    return (dw + int'(pe) + int'(two) + 1) * p + p / 2 + 2;
  endfunction

  // Reference outcome from the line bits alone.
  task automatic model(input int dw, input bit pe, input bit pt, output bit dv, output bit pb,
                       output bit sb);
    bit x;
    x  = pt;
    pb = 1'b0;
    sb = 1'b0;
    for (int i = 1; i <= dw; i++) x ^= fbits[i];
    if (pe) pb = (fbits[dw + 1] != x);
    for (int i = dw + 1 + int'(pe); i < fbits.size(); i++) if (!fbits[i]) sb = 1'b1;
    dv = !pb && !sb;
  endtask

  task automatic check_frame(input string name, input bit sel7, input int start, input int n,
                             input bit edv, input bit epe, input bit ese, input logic [8:0] epd);
    ev_t e;
    int  sz;
    sz = sel7 ? q7.size() : q8.size();
    chk({name, " pulse present"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (sel7) e = q7.pop_front();
      else      e = q8.pop_front();
      chk({name, " cycle"}, e.cyc, start + n);
      chk({name, " Data_Valid"}, 32'(e.dv), 32'(edv));
      chk({name, " Par_Err"}, 32'(e.pe), 32'(epe));
      chk({name, " Stp_Err"}, 32'(e.se), 32'(ese));
      chk({name, " P_DATA"}, 32'(e.pd), 32'(epd));
    end
  endtask

  function automatic vec_t mkv(input bit sel7, input logic [8:0] data, input bit pe, input bit pt,
                               input bit two, input int p, input bit flip, input bit s1b,
                               input bit s2b, input bit e_dv, input bit e_pe, input bit e_se,
                               input logic [8:0] e_pd);
    vec_t v;
    v.sel7 = sel7; v.data = data; v.pe = pe; v.pt = pt; v.two = two; v.p = p;
    v.flip = flip; v.s1b = s1b; v.s2b = s2b;
    v.e_dv = e_dv; v.e_pe = e_pe; v.e_se = e_se; v.e_pd = e_pd;
    return v;
  endfunction

  initial begin : main
    vec_t       v;
    int         st, st2, dw, p;
    bit         pe, pt, two, flip, s1b, s2b, mdv, mpb, msb;
    logic [8:0] data, pd_model;

    //           sel7 data    pe pt two p  flip s1b s2b dv pe se pd
    tbl[0] = mkv(0, 9'h0A5, 0, 0, 0, 8,  0, 0, 0, 1, 0, 0, 9'h0A5);
    tbl[1] = mkv(0, 9'h03C, 1, 0, 0, 16, 0, 0, 0, 1, 0, 0, 9'h03C);
    tbl[2] = mkv(0, 9'h03C, 1, 0, 0, 16, 1, 0, 0, 0, 1, 0, 9'h03C);
    tbl[3] = mkv(1, 9'h02B, 1, 1, 1, 32, 0, 0, 0, 1, 0, 0, 9'h02B);
    tbl[4] = mkv(1, 9'h05A, 1, 1, 1, 32, 0, 0, 1, 0, 0, 1, 9'h02B);
    tbl[5] = mkv(0, 9'h0FF, 1, 0, 1, 6,  1, 1, 0, 0, 1, 1, 9'h03C);
    tbl[6] = mkv(0, 9'h000, 1, 1, 0, 62, 0, 0, 0, 1, 0, 0, 9'h000);
    tbl[7] = mkv(0, 9'h0C3, 0, 0, 1, 10, 0, 1, 0, 0, 0, 1, 9'h000);

    rst_n = 1'b0;
    rx8   = 1'b1;
    rx7   = 1'b1;
    apply_cfg(8, 0, 0, 0);
    @(posedge clk);
    hold(3);
    chk("reset Data_Valid", 32'(dv8), 32'd0);
    chk("reset Par_Err", 32'(pe8), 32'd0);
    chk("reset Stp_Err", 32'(se8), 32'd0);
    chk("reset Busy", 32'({busy8, busy7}), 32'd0);
    chk("reset P_DATA", 32'(pd8), 32'd0);
    rst_n = 1'b1;
    hold(2);

    for (int i = 0; i < 8; i++) begin
      v  = tbl[i];
      dw = v.sel7 ? 7 : 8;
      apply_cfg(v.p, v.pe, v.pt, v.two);
      build_frame(dw, v.data, v.pe, v.pt, v.two, v.flip, v.s1b, v.s2b);
      send_frame(v.sel7, v.p, v.p, st);
      hold(3);
      check_frame($sformatf("vec%0d", i), v.sel7, st, lat(dw, v.pe, v.two, v.p),
                  v.e_dv, v.e_pe, v.e_se, v.e_pd);
    end
    chk("vec stray pulses", q8.size() + q7.size(), 0);

    // Start glitch: three low cycles, rejected at the decision edge.
    apply_cfg(16, 0, 0, 0);
    set_rx(0, 0);
    hold(3);
    set_rx(0, 1);
    hold(3);
    chk("glitch Busy during start", 32'(busy8), 32'd1);
    hold(6);
    chk("glitch Busy fell", 32'(busy8), 32'd0);
    chk("glitch no pulse", q8.size(), 0);
    build_frame(8, 9'h055, 0, 0, 0, 0, 0, 0);
    send_frame(0, 16, 16, st);
    hold(2);
    check_frame("after glitch", 0, st, lat(8, 0, 0, 16), 1, 0, 0, 9'h055);

    // Break: line held low for three frame times.
    apply_cfg(8, 0, 0, 0);
    set_rx(0, 0);
    st = cyc;
    hold(30 * 8);
    chk("break Busy held", 32'(busy8), 32'd1);
    check_frame("break", 0, st, lat(8, 0, 0, 8), 0, 0, 1, 9'h055);
    chk("break single pulse", q8.size(), 0);
    set_rx(0, 1);
    hold(2);
    chk("break released Busy", 32'(busy8), 32'd0);
    apply_cfg(8, 0, 0, 0);
    build_frame(8, 9'h081, 0, 0, 0, 0, 0, 0);
    send_frame(0, 8, 8, st);
    hold(2);
    check_frame("after break", 0, st, lat(8, 0, 0, 8), 1, 0, 0, 9'h081);

    // Back-to-back: next start edge lands in the IDLE cycle right after DONE.
    apply_cfg(8, 0, 0, 0);
    build_frame(8, 9'h096, 0, 0, 0, 0, 0, 0);
    send_frame(0, 8, 8 / 2 + 3, st);
    apply_cfg(8, 0, 0, 0);
    build_frame(8, 9'h069, 0, 0, 0, 0, 0, 0);
    send_frame(0, 8, 8, st2);
    hold(2);
    chk("b2b no gap", st2 - st, lat(8, 0, 0, 8) + 1);
    check_frame("b2b first", 0, st, lat(8, 0, 0, 8), 1, 0, 0, 9'h096);
    check_frame("b2b second", 0, st2, lat(8, 0, 0, 8), 1, 0, 0, 9'h069);

    // Reset in the middle of the data bits of a 0xFF frame.
    apply_cfg(16, 0, 0, 0);
    set_rx(0, 0);
    hold(16);
    set_rx(0, 1);
    hold(40);
    rst_n = 1'b0;
    #1;
    chk("mid reset Busy", 32'(busy8), 32'd0);
    chk("mid reset P_DATA", 32'(pd8), 32'd0);
    chk("mid reset Data_Valid", 32'(dv8), 32'd0);
    hold(2);
    rst_n = 1'b1;
    hold(200);
    chk("aborted frame no pulse", q8.size(), 0);
    apply_cfg(16, 0, 0, 0);
    build_frame(8, 9'h00F, 0, 0, 0, 0, 0, 0);
    send_frame(0, 16, 16, st);
    hold(2);
    check_frame("after reset", 0, st, lat(8, 0, 0, 16), 1, 0, 0, 9'h00F);

    // Randomised frames against the reference model.
    pd_model = 9'h00F;
    for (int i = 0; i < 16; i++) begin
      p    = 2 * int'($urandom_range(3, 31));
      data = 9'($urandom_range(0, 255));
      pe   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      two  = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 3) == 0);
      s1b  = ($urandom_range(0, 3) == 0);
      s2b  = ($urandom_range(0, 3) == 0);
      apply_cfg(p, pe, pt, two);
      build_frame(8, data, pe, pt, two, flip, s1b, s2b);
      model(8, pe, pt, mdv, mpb, msb);
      if (mdv) pd_model = data;
      send_frame(0, p, p, st);
      hold(int'($urandom_range(1, 4)));
      check_frame($sformatf("rand%0d", i), 0, st, lat(8, pe, two, p), mdv, mpb, msb, pd_model);
    end

    hold(4);
    chk("final stray pulses", q8.size() + q7.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
